decoder_sweep: RTL

//   Parametrised, registered N-to-2^N one-hot decoder that drives the

---
 rtl/decoder_sweep_if.sv | 32 +++
 rtl/decoder_sweep.sv | 93 +++++++++
 2 files changed

// File: rtl/decoder_sweep_if.sv
// Decode/sweep request and one-hot select bundle.
// master drives requests, slave returns selects.
interface decoder_sweep_if #(
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic [SEL_W-1:0] sel;
  logic             sweep_start;
  logic [N-1:0]     d;
  logic             busy;
  logic             done;

  modport master (
    output en,
    output sel,
    output sweep_start,
    input  d,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  sel,
    input  sweep_start,
    output d,
    output busy,
    output done
  );
endinterface

// File: rtl/decoder_sweep.sv
// Registered N-to-2^N one-hot write-select decoder
// with a one-hot sweep mode for register-file clear.
module decoder_sweep #(
  parameter int SEL_W    = 3,
  parameter bit MASK_TOP = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  decoder_sweep_if.slave bus
);
  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST = {SEL_W{1'b1}};

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] cnt_inc;

  // Top line can be a hard-wired zero register.
  function automatic logic [N-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    if (MASK_TOP) r[N-1] = 1'b0;
    return r;
  endfunction

  assign cnt_inc = cnt_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
          d_d     = onehot('0);
          busy_d  = 1'b1;
        end else if (bus.en) begin
          d_d = onehot(bus.sel);
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_inc;
          d_d    = onehot(cnt_inc);
          busy_d = 1'b1;
          done_d = (cnt_inc == LAST);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
